// File: rtl/alu4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu4_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one 4-bit ALU among four
//            requesters; latches operands, waits EXEC_CYCLES, returns result.
// Revision : 1.0 - initial release
// ============================================================================
module alu4_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [11:0] op_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  alu_y,
  input  logic [3:0]  alu_flags,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [3:0]  result,
  output logic [3:0]  flags,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  res_q, res_d;
  logic [3:0]  flg_q, flg_d;

  logic        win_vld;
  logic [1:0]  win_idx;

  // Search ptr, ptr+1, ... ; iterating downward lets the nearest hit win.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = done_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = 4'b0001 << win_idx;
          op_d    = op_in[int'(win_idx) * 3 +: 3];
          a_d     = a_in[int'(win_idx) * 4 +: 4];
          b_d     = b_in[int'(win_idx) * 4 +: 4];
          cnt_d   = CNT_INIT;
          ptr_d   = win_idx + 2'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_y;
          flg_d   = alu_flags;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        done_d  = 4'b0000;
        grant_d = 4'b0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      grant_q <= 4'd0;
      done_q  <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      res_q   <= 4'd0;
      flg_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign result = res_q;
  assign flags  = flg_q;
  assign busy   = (state_q == S_EXEC) || (state_q == S_DONE);

endmodule
`default_nettype wire
